// File: rtl/cfg_dat_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cfg_dat_pkg                                                   |
// | Purpose  : Shared types and helpers for the cfg_dat_stream slice.        |
// |            - state_t     : stream FSM encoding (IDLE, SEND)              |
// |            - clog2       : index width, never below 1                    |
// |            - field_slice : field k of a word, field 0 in the MSBs        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package cfg_dat_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Upper bound on NUM_FIELDS*FIELD_W that field_slice can address
  // (64 fields of up to 64 bits each).
  localparam int unsigned MAX_DAT_W = 4096;

  // Ceiling log2 with a floor of 1, so that a single-field build still
  // has a one-bit index port.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  // Field k of a word holding num_fields fields of field_w bits each.
  // Field 0 is the most significant. The result is right-aligned; the
  // caller truncates it to field_w bits.
  function automatic logic [MAX_DAT_W-1:0] field_slice(
    input logic [MAX_DAT_W-1:0] word,
    input int unsigned          k,
    input int unsigned          num_fields,
    input int unsigned          field_w
  );
    logic [MAX_DAT_W-1:0] lsb_mask;
    lsb_mask = ~({MAX_DAT_W{1'b1}} << field_w);
    return (word >> ((num_fields - 1 - k) * field_w)) & lsb_mask;
  endfunction

endpackage : cfg_dat_pkg
`default_nettype wire

// File: rtl/cfg_dat_next_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cfg_dat_next_sel                                              |
// | Purpose  : Combinational set-bit finder for the field-enable mask.       |
// | Ports    : i_mask      - field enable mask                               |
// |            i_ptr       - current field index                             |
// |            o_next_idx  - lowest set mask bit strictly above i_ptr        |
// |            o_has_next  - a set mask bit exists above i_ptr               |
// |            o_first_idx - lowest set mask bit (0 when the mask is empty)  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cfg_dat_next_sel #(
  parameter int unsigned NUM_FIELDS = 11,
  parameter int unsigned IDX_W      = 4
) (
  input  logic [NUM_FIELDS-1:0] i_mask,
  input  logic [IDX_W-1:0]      i_ptr,
  output logic [IDX_W-1:0]      o_next_idx,
  output logic                  o_has_next,
  output logic [IDX_W-1:0]      o_first_idx
);

  // Scanning from the top down, the final hit is the lowest qualifying bit.
  always_comb begin
    o_next_idx  = '0;
    o_has_next  = 1'b0;
    o_first_idx = '0;
    for (int k = NUM_FIELDS - 1; k >= 0; k--) begin
      if (i_mask[k]) begin
        o_first_idx = IDX_W'(k);
        if (IDX_W'(k) > i_ptr) begin
          o_next_idx = IDX_W'(k);
          o_has_next = 1'b1;
        end
      end
    end
  end

endmodule : cfg_dat_next_sel
`default_nettype wire

// File: rtl/cfg_dat_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cfg_dat_stream                                                |
// | Purpose  : Registers one wide config word per valid/ready handshake and  |
// |            presents its fields as a one-cycle parallel snapshot strobe   |
// |            and as a serial stream of the mask-enabled fields.            |
// | Ports    : clk, reset (async, active-high)                               |
// |            t_0_dat/t_0_mask/t_0_valid/t_0_ready : config word input      |
// |            i_0_dat/i_0_idx/i_0_last/i_0_valid/i_0_ready : field stream   |
// |            i_1_dat/i_1_valid : registered snapshot + update strobe       |
// |            busy : stream drain in progress                               |
// | Note     : t_0_ready depends combinationally on i_0_ready, which lets a  |
// |            new word be taken on the last beat with no idle cycle.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cfg_dat_stream
  import cfg_dat_pkg::*;
#(
  parameter  int unsigned CFG_W      = 512,
  parameter  int unsigned FIELD_W    = 8,
  parameter  int unsigned NUM_FIELDS = 11,
  localparam int unsigned IDX_W      = clog2(NUM_FIELDS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CFG_W-1:0]              t_0_dat,
  input  logic [NUM_FIELDS-1:0]         t_0_mask,
  input  logic                          t_0_valid,
  output logic                          t_0_ready,
  output logic [FIELD_W-1:0]            i_0_dat,
  output logic [IDX_W-1:0]              i_0_idx,
  output logic                          i_0_last,
  output logic                          i_0_valid,
  input  logic                          i_0_ready,
  output logic [NUM_FIELDS*FIELD_W-1:0] i_1_dat,
  output logic                          i_1_valid,
  output logic                          busy
);

  localparam int unsigned DAT_W = NUM_FIELDS * FIELD_W;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      w_ptr_nxt;
  logic [DAT_W-1:0]      r_word;
  logic [NUM_FIELDS-1:0] r_mask;
  logic                  r_snap_vld;

  logic                  w_sending;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_accept;

  logic [IDX_W-1:0]      w_next_cur;
  logic                  w_has_next_cur;
  logic [IDX_W-1:0]      w_first_cur;
  logic [IDX_W-1:0]      w_next_new;
  logic                  w_has_next_new;
  logic [IDX_W-1:0]      w_first_new;

  // Advance selection: next enabled field of the word being drained.
  cfg_dat_next_sel #(
    .NUM_FIELDS (NUM_FIELDS),
    .IDX_W      (IDX_W)
  ) u_sel_cur (
    .i_mask      (r_mask),
    .i_ptr       (r_ptr),
    .o_next_idx  (w_next_cur),
    .o_has_next  (w_has_next_cur),
    .o_first_idx (w_first_cur)
  );

  // Initial selection: first enabled field of the word being offered.
  cfg_dat_next_sel #(
    .NUM_FIELDS (NUM_FIELDS),
    .IDX_W      (IDX_W)
  ) u_sel_new (
    .i_mask      (t_0_mask),
    .i_ptr       ('0),
    .o_next_idx  (w_next_new),
    .o_has_next  (w_has_next_new),
    .o_first_idx (w_first_new)
  );

  // Field view of the registered word. The slice positions are constant
  // per generate iteration, so each reduces to plain wiring.
  logic [MAX_DAT_W-1:0] w_word_ext;
  logic [FIELD_W-1:0]   w_fields [NUM_FIELDS];

  assign w_word_ext = MAX_DAT_W'(r_word);

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_fields
    assign w_fields[k] = FIELD_W'(field_slice(w_word_ext, k, NUM_FIELDS, FIELD_W));
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sending   = (r_state == SEND);
    w_beat      = w_sending & i_0_ready;
    w_last      = w_sending & ~w_has_next_cur;
    t_0_ready   = ~w_sending | (w_beat & w_last);
    w_accept    = t_0_valid & t_0_ready;

    // Accept takes priority: on a last-beat accept the outgoing beat still
    // shows the old word, and the pointer reloads from the new mask.
    if (w_accept) begin
      w_state_nxt = (|t_0_mask) ? SEND : IDLE;
      w_ptr_nxt   = w_first_new;
    end else if (w_beat) begin
      if (w_last) begin
        w_state_nxt = IDLE;
      end else begin
        w_ptr_nxt = w_next_cur;
      end
    end

    i_0_valid = w_sending;
    busy      = w_sending;
    i_0_last  = w_last;
    i_0_idx   = w_sending ? r_ptr : '0;
    i_0_dat   = w_sending ? w_fields[r_ptr] : '0;
    i_1_dat   = r_word;
    i_1_valid = r_snap_vld;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_word     <= '0;
      r_mask     <= '0;
      r_snap_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_snap_vld <= w_accept;
      if (w_accept) begin
        r_word <= t_0_dat[DAT_W-1:0];
        r_mask <= t_0_mask;
      end
    end
  end

  // Bits of the config word above the field map are ignored by design, and
  // some selector outputs are not needed in every role.
  logic w_unused_upper;
  if (CFG_W > DAT_W) begin : g_upper_ignored
    assign w_unused_upper = ^t_0_dat[CFG_W-1:DAT_W];
  end else begin : g_upper_none
    assign w_unused_upper = 1'b0;
  end

  logic w_unused;
  assign w_unused = ^{w_unused_upper, w_first_cur, w_next_new, w_has_next_new};

endmodule : cfg_dat_stream
`default_nettype wire

// File: tb/tb_cfg_dat_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cfg_dat_stream                                             |
// | Purpose  : Self-checking bench for cfg_dat_stream (11 x 8-bit fields in  |
// |            a 512-bit word). A queue model of expected beats and snapshot |
// |            is compared every cycle; literal checks pin key values.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_cfg_dat_stream;

  localparam int unsigned CFG_W      = 512;
  localparam int unsigned FIELD_W    = 8;
  localparam int unsigned NUM_FIELDS = 11;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned DAT_W      = NUM_FIELDS * FIELD_W;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [CFG_W-1:0]      t_0_dat;
  logic [NUM_FIELDS-1:0] t_0_mask;
  logic                  t_0_valid;
  logic                  t_0_ready;
  logic [FIELD_W-1:0]    i_0_dat;
  logic [IDX_W-1:0]      i_0_idx;
  logic                  i_0_last;
  logic                  i_0_valid;
  logic                  i_0_ready = 1'b1;
  logic [DAT_W-1:0]      i_1_dat;
  logic                  i_1_valid;
  logic                  busy;

  always #5 clk = ~clk;

  cfg_dat_stream #(
    .CFG_W      (CFG_W),
    .FIELD_W    (FIELD_W),
    .NUM_FIELDS (NUM_FIELDS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .t_0_dat   (t_0_dat),
    .t_0_mask  (t_0_mask),
    .t_0_valid (t_0_valid),
    .t_0_ready (t_0_ready),
    .i_0_dat   (i_0_dat),
    .i_0_idx   (i_0_idx),
    .i_0_last  (i_0_last),
    .i_0_valid (i_0_valid),
    .i_0_ready (i_0_ready),
    .i_1_dat   (i_1_dat),
    .i_1_valid (i_1_valid),
    .busy      (busy)
  );

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [FIELD_W-1:0] dat;
    logic               last;
  } beat_t;

  beat_t            q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               n_beats = 0;
  int               n_strobes = 0;
  logic [7:0]       cur_base = 8'h00;
  logic             bp_mode = 1'b0;
  int               bp_cnt = 0;
  logic [DAT_W-1:0] exp_snap = '0;
  logic             strobe_pend = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CFG_W-1:0] make_word(input logic [7:0] base);
    logic [CFG_W-1:0] w;
    w = '1;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      w[(NUM_FIELDS - k) * FIELD_W - 1 -: FIELD_W] = base + 8'(k);
    end
    return w;
  endfunction

  // Model and per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    logic       exp_v;
    logic       exp_rdy;
    logic       lastf;
    logic [7:0] fb;
    if (reset) begin
      check("rst_i_0_valid", 128'(i_0_valid), 128'(0));
      check("rst_i_0_dat",   128'(i_0_dat),   128'(0));
      check("rst_i_0_idx",   128'(i_0_idx),   128'(0));
      check("rst_i_0_last",  128'(i_0_last),  128'(0));
      check("rst_i_1_dat",   128'(i_1_dat),   128'(0));
      check("rst_i_1_valid", 128'(i_1_valid), 128'(0));
      check("rst_busy",      128'(busy),      128'(0));
      check("rst_t_0_ready", 128'(t_0_ready), 128'(1));
      q.delete();
      exp_snap    = '0;
      strobe_pend = 1'b0;
      bp_cnt      = 0;
    end else begin
      exp_v = (q.size() != 0);
      check("i_0_valid", 128'(i_0_valid), 128'(exp_v));
      check("busy",      128'(busy),      128'(exp_v));
      exp_rdy = 1'b1;
      if (exp_v) begin
        exp_rdy = i_0_ready && q[0].last;
        if (i_0_valid) begin
          check("i_0_dat",  128'(i_0_dat),  128'(q[0].dat));
          check("i_0_idx",  128'(i_0_idx),  128'(q[0].idx));
          check("i_0_last", 128'(i_0_last), 128'(q[0].last));
        end
      end
      check("t_0_ready", 128'(t_0_ready), 128'(exp_rdy));
      check("i_1_valid", 128'(i_1_valid), 128'(strobe_pend));
      check("i_1_dat",   128'(i_1_dat),   128'(exp_snap));
      if (i_1_valid) n_strobes++;
      if (exp_v && i_0_ready) begin
        void'(q.pop_front());
        n_beats++;
      end
      strobe_pend = 1'b0;
      if (t_0_valid && exp_rdy) begin
        exp_snap = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
          fb       = cur_base + 8'(k);
          exp_snap = {exp_snap[DAT_W-9:0], fb};
          if (t_0_mask[k]) begin
            lastf = 1'b1;
            for (int j = k + 1; j < NUM_FIELDS; j++) begin
              if (t_0_mask[j]) lastf = 1'b0;
            end
            q.push_back('{idx: IDX_W'(k), dat: fb, last: lastf});
          end
        end
        strobe_pend = 1'b1;
      end
      if (i_0_valid && !i_0_ready) bp_cnt++;
      else bp_cnt = 0;
    end
  end

  // Stream consumer: always ready, or ready only on the third cycle of a beat.
  always @(posedge clk) begin
    #1;
    if (bp_mode) i_0_ready = (bp_cnt == 2);
    else         i_0_ready = 1'b1;
  end

  task automatic send(input logic [7:0] base, input logic [NUM_FIELDS-1:0] mask);
    int n;
    t_0_dat   = make_word(base);
    t_0_mask  = mask;
    cur_base  = base;
    t_0_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!t_0_ready && n < 200);
    check("send_accept", 128'(t_0_ready), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    t_0_valid = 1'b0;
    t_0_dat   = {16{$urandom}};
    t_0_mask  = NUM_FIELDS'($urandom);
    cur_base  = 8'hEE;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || q.size() != 0) && n < 200);
    check("drain_done", 128'(busy), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    int b;
    int s;
    int n;
    reset     = 1'b1;
    t_0_valid = 1'b0;
    t_0_dat   = '0;
    t_0_mask  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // All fields enabled.
    b = n_beats; s = n_strobes;
    send(8'h10, 11'h7FF);
    go_idle();
    check("t1_first_valid", 128'(i_0_valid), 128'(1));
    check("t1_first_dat",   128'(i_0_dat),   128'(8'h10));
    check("t1_first_idx",   128'(i_0_idx),   128'(0));
    check("t1_strobe",      128'(i_1_valid), 128'(1));
    drain();
    check("t1_beats",   128'(n_beats - b),   128'(11));
    check("t1_strobes", 128'(n_strobes - s), 128'(1));
    check("t1_snap",    128'(i_1_dat),       128'(88'h101112131415161718191A));

    // Sparse mask 0x405: fields 0, 2, 10 with no gaps.
    b = n_beats;
    send(8'h10, 11'h405);
    go_idle();
    check("t2_b0_idx", 128'(i_0_idx), 128'(0));
    check("t2_b0_dat", 128'(i_0_dat), 128'(8'h10));
    @(posedge clk); #1;
    check("t2_b1_idx",  128'(i_0_idx),  128'(2));
    check("t2_b1_dat",  128'(i_0_dat),  128'(8'h12));
    check("t2_b1_last", 128'(i_0_last), 128'(0));
    @(posedge clk); #1;
    check("t2_b2_idx",  128'(i_0_idx),  128'(10));
    check("t2_b2_dat",  128'(i_0_dat),  128'(8'h1A));
    check("t2_b2_last", 128'(i_0_last), 128'(1));
    drain();
    check("t2_beats", 128'(n_beats - b), 128'(3));

    // Empty mask: snapshot strobe only.
    b = n_beats; s = n_strobes;
    send(8'h30, 11'h000);
    go_idle();
    check("t3_strobe", 128'(i_1_valid), 128'(1));
    check("t3_valid",  128'(i_0_valid), 128'(0));
    check("t3_ready",  128'(t_0_ready), 128'(1));
    @(posedge clk); #1;
    check("t3_strobe_off", 128'(i_1_valid), 128'(0));
    drain();
    check("t3_beats",   128'(n_beats - b),   128'(0));
    check("t3_strobes", 128'(n_strobes - s), 128'(1));
    check("t3_snap",    128'(i_1_dat),       128'(88'h303132333435363738393A));

    // Back-to-back words, second offered during the first's drain.
    b = n_beats; s = n_strobes;
    send(8'h10, 11'h7FF);
    send(8'h20, 11'h7FF);
    check("t4_b2b_valid", 128'(i_0_valid), 128'(1));
    check("t4_b2b_dat",   128'(i_0_dat),   128'(8'h20));
    check("t4_b2b_idx",   128'(i_0_idx),   128'(0));
    go_idle();
    drain();
    check("t4_beats",   128'(n_beats - b),   128'(22));
    check("t4_strobes", 128'(n_strobes - s), 128'(2));

    // Backpressure: each beat held three cycles.
    bp_mode = 1'b1;
    b = n_beats;
    send(8'h40, 11'h0F3);
    go_idle();
    check("t5_h0_dat", 128'(i_0_dat), 128'(8'h40));
    @(posedge clk); #1;
    check("t5_h1_dat",   128'(i_0_dat),   128'(8'h40));
    check("t5_h1_ready", 128'(t_0_ready), 128'(0));
    @(posedge clk); #1;
    check("t5_h2_dat", 128'(i_0_dat), 128'(8'h40));
    @(posedge clk); #1;
    check("t5_b1_dat", 128'(i_0_dat), 128'(8'h41));
    check("t5_b1_idx", 128'(i_0_idx), 128'(1));
    drain();
    check("t5_beats", 128'(n_beats - b), 128'(6));
    bp_mode = 1'b0;
    @(posedge clk); #1;

    // Reset while field 4 is on the stream.
    b = n_beats;
    send(8'h50, 11'h7FF);
    go_idle();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(i_0_valid && i_0_idx == 4'd3) && n < 50);
    check("t6_reach_idx3", 128'(i_0_idx), 128'(3));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 128'(i_0_valid), 128'(0));
    check("t6_rst_snap",  128'(i_1_dat),   128'(0));
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_beats_before_rst", 128'(n_beats - b), 128'(4));
    b = n_beats;
    send(8'h60, 11'h7FF);
    go_idle();
    check("t6_fresh_dat", 128'(i_0_dat), 128'(8'h60));
    check("t6_fresh_idx", 128'(i_0_idx), 128'(0));
    drain();
    check("t6_beats", 128'(n_beats - b), 128'(11));
    check("t6_snap",  128'(i_1_dat),     128'(88'h606162636465666768696A));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cfg_dat_stream
`default_nettype wire

// File: doc/cfg_dat_stream.md
Name: cfg_dat_stream

Overview:
- Parametrised successor to the fixed 11×8-bit config-word slicer.
- Accepts one wide config word per valid/ready handshake, registers it, and exposes the sliced fields in two ways:
  - as a registered parallel snapshot;
  - as a per-field serial stream, with a per-word field-enable mask.
- Sits between the config-word source and the field consumers in the piston config path. Downstream blocks may take a whole snapshot or drain only the enabled fields one per cycle.

Parameters:
- CFG_W, 512, width of the incoming config word.
- FIELD_W, 8, width of one field.
- NUM_FIELDS, 11, field count. Legal range 1..64; NUM_FIELDS*FIELD_W <= CFG_W.
- IDX_W, clog2(NUM_FIELDS) min 1, width of the field-index output (derived, not overridden).

Ports:
- clk, input, 1, sole clock; all logic rising-edge.
- reset, input, 1, asynchronous, active-high reset.
- t_0_dat, input, CFG_W, incoming config word.
- t_0_mask, input, NUM_FIELDS, field enable; bit k enables field k. Sampled with t_0_dat.
- t_0_valid, input, 1, word/mask valid.
- t_0_ready, output, 1, block can accept a word this cycle.
- i_0_dat, output, FIELD_W, current streamed field.
- i_0_idx, output, IDX_W, index of current streamed field.
- i_0_last, output, 1, current beat is the last enabled field of the word.
- i_0_valid, output, 1, stream beat valid.
- i_0_ready, input, 1, stream consumer ready.
- i_1_dat, output, NUM_FIELDS*FIELD_W, registered snapshot; field 0 in the MSBs.
- i_1_valid, output, 1, one-cycle strobe: i_1_dat updated.
- busy, output, 1, stream drain in progress.

Behaviour:
- Field map: only the low NUM_FIELDS*FIELD_W bits of t_0_dat are used; upper bits are ignored. Field k = t_0_dat[(NUM_FIELDS-k)*FIELD_W-1 -: FIELD_W], so field 0 is the most significant field.
- Reset (async assert, sync release): state=IDLE, all registers 0. Outputs: i_0_valid=0, i_0_dat=0, i_0_idx=0, i_0_last=0, i_1_dat=0, i_1_valid=0, busy=0, t_0_ready=1 (follows state).
- FSM states: IDLE, SEND.
- Accept occurs when t_0_valid & t_0_ready. At accept cycle N:
  - word and mask are registered;
  - i_1_dat updates and i_1_valid=1 at N+1, for exactly one cycle;
  - if mask!=0: next state is SEND, ptr = lowest set mask bit;
  - if mask==0: stay IDLE; snapshot still updates and strobes; no stream beats.
- IDLE: t_0_ready=1, i_0_valid=0, busy=0.
- SEND: i_0_valid=1, busy=1, i_0_dat = field[ptr], i_0_idx = ptr.
  - i_0_last=1 iff there is no set mask bit above ptr.
  - Outputs are stable while i_0_ready=0 (AXI-style hold; valid never drops without a handshake).
- Beat handshake (i_0_valid & i_0_ready):
  - not last: ptr advances to the next set mask bit (skips disabled fields; no bubble cycles);
  - last: if t_0_valid in the same cycle, accept the new word and go to SEND or IDLE per the new mask. Otherwise go to IDLE.
- t_0_ready = (state==IDLE) | (i_0_valid & i_0_ready & i_0_last). This is a combinational path from i_0_ready and is documented for integration. It gives back-to-back words with zero idle cycles.
- Latency: accept at N → first beat valid at N+1. A word with E enabled fields drains in E cycles under constant i_0_ready.
- Simultaneous accept and last-beat: the outgoing beat uses the old word. The new snapshot strobe occurs at N+1 with the new word.
- Reset mid-drain: remaining beats are discarded, the snapshot clears to 0, and no strobe is issued.
- t_0_dat and t_0_mask are don't-care when t_0_valid=0.

Decomposition:
- Package cfg_dat_pkg:
  - state enum {IDLE, SEND};
  - function clog2 for IDX_W;
  - function field_slice(word, k) for the field map.
- One sub-module, cfg_dat_next_sel: combinational.
  - Input: mask, ptr.
  - Outputs: next set index above ptr, has_next flag, first set index of the mask.
  - Used for both initial selection and advance.

Test Plan (NUM_FIELDS=11, FIELD_W=8, CFG_W=512):
- Word with field k = 0x10+k (low 88 bits = 0x101112…1A), upper bits 0xFF…, mask=0x7FF, i_0_ready=1 → i_1_dat=0x10…1A with a 1-cycle strobe at N+1. Then 11 beats, idx 0..10, dat 0x10..0x1A, last only on idx 10; upper bits never appear.
- Same word, mask=0x405 → 3 beats: idx 0/0x10, idx 2/0x12, idx 10/0x1A with last; no gap cycles.
- mask=0x000 → i_1_valid strobes once, i_0_valid stays 0, t_0_ready stays 1.
- Back-to-back: second word (field k = 0x20+k) valid during last beat of first → accepted that cycle; first beat of second word (0x20) appears the very next cycle.
- Backpressure: i_0_ready toggles 0,0,1 per beat → each beat held stable 3 cycles; t_0_ready=0 throughout SEND until last handshake.
- Assert reset during beat idx 4 → next cycle i_0_valid=0, i_1_dat=0, t_0_ready=1; a fresh word then streams normally from idx 0.
